// File: rtl/vx_axi_mem_responder_if.sv
// rtl/vx_axi_mem_responder_if.sv - AXI4 AW/W/B/AR/R bundle between the Vortex master and the memory responder
// Purpose: groups the five AXI4 channels of the Vortex memory link.
// Ports (signals): aw* write request, w* write data, b* write response,
//                  ar* read request, r* read data; master drives requests, slave answers.
interface vx_axi_mem_responder_if #(
    parameter int AXI_DATA_WIDTH   = 512,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_TID_WIDTH    = 8,
    parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
);
    logic [AXI_TID_WIDTH-1:0]    awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic                        awready;

    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_STROBE_WIDTH-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;

    logic [AXI_TID_WIDTH-1:0]    bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;

    logic [AXI_TID_WIDTH-1:0]    arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;

    logic [AXI_TID_WIDTH-1:0]    rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/vx_axi_mem_responder.sv
// rtl/vx_axi_mem_responder.sv - AXI4 slave answering the Vortex master from a local word array
// Purpose: independent write and read burst engines over a 2^MEM_WORDS_LOG2-word memory.
// Ports: clk, reset (async active-low), s_axi (slave side of the AXI4 bundle),
//        busy (either engine not idle).
module vx_axi_mem_responder #(
    parameter int AXI_DATA_WIDTH   = 512,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_TID_WIDTH    = 8,
    parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int MEM_WORDS_LOG2   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_axi_mem_responder_if.slave s_axi,
    output logic                  busy
);
    localparam int OFF   = $clog2(AXI_STROBE_WIDTH);
    localparam int MW    = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << MW;
    // Wide enough to hold start index + len without wrapping.
    localparam int SUMW  = ((MW > 8) ? MW : 8) + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [MW-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Whole burst is rejected if any address bit sits above the index field
    // or the last beat would fall past the top of the array.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                          input logic [7:0] len);
        logic [AXI_ADDR_WIDTH-1:0] hi;
        logic [SUMW-1:0]           last;
        hi   = addr >> (OFF + MW);
        last = SUMW'(addr[OFF +: MW]) + SUMW'(len);
        return (hi != '0) || (last >= SUMW'(DEPTH));
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write engine ----------------
    wstate_t                  wstate_q;
    logic                     awready_q, wready_q, bvalid_q;
    logic [AXI_TID_WIDTH-1:0] bid_q;
    logic [1:0]               bresp_q, bresp_d;
    idx_t                     w_idx_q;
    logic [7:0]               w_len_q, w_cnt_q;
    logic                     w_fire, w_is_last, aw_dec;
    idx_t                     w_addr;

    assign w_fire    = (wstate_q == W_DATA) && s_axi.wvalid && wready_q;
    assign w_is_last = (w_cnt_q == w_len_q);
    assign w_addr    = w_idx_q + idx_t'(w_cnt_q);
    assign aw_dec    = out_of_range(s_axi.awaddr, s_axi.awlen);

    // A wlast that disagrees with the beat count downgrades OKAY to SLVERR;
    // DECERR always wins.
    always_comb begin
        bresp_d = bresp_q;
        if (w_fire && (s_axi.wlast != w_is_last) && (bresp_q != RESP_DECERR))
            bresp_d = RESP_SLVERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi.awvalid && awready_q) begin
                        bid_q     <= s_axi.awid;
                        w_idx_q   <= s_axi.awaddr[OFF +: MW];
                        w_len_q   <= s_axi.awlen;
                        w_cnt_q   <= '0;
                        bresp_q   <= aw_dec ? RESP_DECERR : RESP_OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        bresp_q <= bresp_d;
                        if (w_is_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            wstate_q <= W_RESP;
                        end else begin
                            w_cnt_q <= w_cnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready && bvalid_q) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_fire && (bresp_q != RESP_DECERR)) begin
            for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
                if (s_axi.wstrb[b])
                    mem_q[w_addr][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    rstate_t                   rstate_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [AXI_TID_WIDTH-1:0]  rid_q;
    logic [1:0]                rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    idx_t                      r_idx_q;
    logic [7:0]                r_len_q, r_cnt_q;
    logic                      r_fire, ar_dec;
    idx_t                      r_next_idx;

    assign r_fire     = rvalid_q && s_axi.rready;
    assign r_next_idx = r_idx_q + idx_t'(r_cnt_q) + idx_t'(1);
    assign ar_dec     = out_of_range(s_axi.araddr, s_axi.arlen);

    // rdata is preloaded one beat ahead so it is valid with rvalid and holds
    // across rready stalls; a same-cycle write lands after this load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.arvalid && arready_q) begin
                        rid_q     <= s_axi.arid;
                        r_idx_q   <= s_axi.araddr[OFF +: MW];
                        r_len_q   <= s_axi.arlen;
                        r_cnt_q   <= '0;
                        rresp_q   <= ar_dec ? RESP_DECERR : RESP_OKAY;
                        rdata_q   <= ar_dec ? '0 : mem_q[s_axi.araddr[OFF +: MW]];
                        rlast_q   <= (s_axi.arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q + 8'd1;
                            rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
                            rdata_q <= (rresp_q == RESP_DECERR) ? '0 : mem_q[r_next_idx];
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign busy = (wstate_q != W_IDLE) | (rstate_q != R_IDLE);

    // Size, burst type and sub-word address bits carry no meaning here.
    logic unused_sigs;
    assign unused_sigs = ^{s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                           s_axi.awaddr[OFF-1:0], s_axi.araddr[OFF-1:0]};
endmodule

// File: tb/tb_vx_axi_mem_responder.sv
// tb/tb_vx_axi_mem_responder.sv - self-checking bench for vx_axi_mem_responder
module tb_vx_axi_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int vectors = 0;
    int miscompares = 0;

    vx_axi_mem_responder_if axi ();

    vx_axi_mem_responder dut (
        .clk   (clk),
        .reset (rst_n),
        .s_axi (axi),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: byte-accurate image of the array plus per-beat stimulus buffers.
    logic [511:0] ref_mem [4096];
    logic [511:0] wd [256];
    logic [63:0]  ws [256];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit is_decerr(input logic [31:0] addr, input int len);
        longint w;
        w = longint'(addr) / 64;
        return (w + len) >= 4096;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr,
                            input int len, input int early_last);
        bit dec, mism;
        int n, word;
        logic [1:0] exp_resp;
        dec = is_decerr(addr, len);
        mism = 0;
        word = int'(addr / 64);
        axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len);
        axi.awsize = 3'd6; axi.awburst = 2'b01; axi.awvalid = 1'b1;
        n = 0;
        while (axi.awready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("aw_ready", axi.awready, 1'b1);
        tick();
        axi.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            axi.wdata = wd[k];
            axi.wstrb = ws[k];
            axi.wlast = (early_last >= 0) ? (k == early_last) : (k == len);
            axi.wvalid = 1'b1;
            if (axi.wlast != (k == len)) mism = 1;
            chk("w_ready", axi.wready, 1'b1);
            tick();
            if (!dec)
                for (int b = 0; b < 64; b++)
                    if (ws[k][b]) ref_mem[word + k][b*8 +: 8] = wd[k][b*8 +: 8];
        end
        axi.wvalid = 1'b0;
        axi.wlast = 1'b0;
        exp_resp = dec ? 2'b11 : (mism ? 2'b10 : 2'b00);
        chk("b_valid", axi.bvalid, 1'b1);
        chk("b_id", axi.bid, id);
        chk("b_resp", axi.bresp, exp_resp);
        chk("w_ready_after", axi.wready, 1'b0);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("b_valid_clear", axi.bvalid, 1'b0);
        chk("aw_ready_again", axi.awready, 1'b1);
    endtask

    // mode 0: rready held high, 1: random rready, 2: rready pattern 1,0,0,1
    task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                           input int len, input int mode);
        bit dec, hs;
        int n, k, cyc, word;
        logic [511:0] exp;
        bit pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        dec = is_decerr(addr, len);
        word = int'(addr / 64);
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len);
        axi.arsize = 3'd6; axi.arburst = 2'b01; axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("ar_ready", axi.arready, 1'b1);
        tick();
        axi.arvalid = 1'b0;
        k = 0;
        cyc = 0;
        while (k <= len && cyc < 2000) begin
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = 1'($urandom_range(0, 1));
                default: axi.rready = pat[cyc % 4];
            endcase
            chk("r_valid", axi.rvalid, 1'b1);
            if (axi.rvalid !== 1'b1) break;
            exp = dec ? '0 : ref_mem[word + k];
            chk("r_data", axi.rdata, exp);
            chk("r_last", axi.rlast, (k == len));
            chk("r_id", axi.rid, id);
            chk("r_resp", axi.rresp, dec ? 2'b11 : 2'b00);
            hs = axi.rready;
            tick();
            if (hs) k++;
            cyc++;
        end
        axi.rready = 1'b0;
        chk("r_beats_done", (k > len), 1'b1);
        chk("r_valid_clear", axi.rvalid, 1'b0);
        chk("ar_ready_again", axi.arready, 1'b1);
    endtask

    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_wready", axi.wready, 1'b0);
        chk("rst_bvalid", axi.bvalid, 1'b0);
        chk("rst_arready", axi.arready, 1'b0);
        chk("rst_rvalid", axi.rvalid, 1'b0);
        chk("rst_rlast", axi.rlast, 1'b0);
        chk("rst_bresp", axi.bresp, 2'b00);
        chk("rst_rresp", axi.rresp, 2'b00);
        chk("rst_rdata", axi.rdata, '0);
        chk("rst_bid", axi.bid, '0);
        chk("rst_rid", axi.rid, '0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_awready", axi.awready, 1'b1);
        chk("post_rst_arready", axi.arready, 1'b1);

        // Fill words 0..63 and 4088..4095 with known data
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = rnd512(); ws[k] = '1; end
            do_write(8'(blk), 32'(blk * 16 * 64), 15, -1);
        end
        for (int k = 0; k < 8; k++) begin wd[k] = rnd512(); ws[k] = '1; end
        do_write(8'h07, 32'(4088 * 64), 7, -1);

        // 4-beat burst 0x11..0x44 at 0x100, read back with rready high
        for (int k = 0; k < 4; k++) begin wd[k] = 512'((k + 1) * 17); ws[k] = '1; end
        do_write(8'h3A, 32'h100, 3, -1);
        do_read(8'h3A, 32'h100, 3, 0);

        // Partial strobe over all-zero word at 0x40
        wd[0] = '0; ws[0] = '1;
        do_write(8'h01, 32'h40, 0, -1);
        wd[0] = '1; ws[0] = 64'h0000_0000_0000_000F;
        do_write(8'h02, 32'h40, 0, -1);
        do_read(8'h03, 32'h40, 0, 0);

        // Stalled read with rready 1,0,0,1
        do_read(8'h11, 32'h100, 3, 2);

        // Out-of-range burst, then confirm word 0 untouched
        for (int k = 0; k < 2; k++) begin wd[k] = rnd512(); ws[k] = '1; end
        do_write(8'h20, 32'h40000, 1, -1);
        do_read(8'h21, 32'h40000, 1, 0);
        do_read(8'h22, 32'h0, 1, 0);

        // Top-of-array boundaries
        wd[0] = rnd512(); ws[0] = '1;
        do_write(8'h30, 32'(4095 * 64), 0, -1);
        for (int k = 0; k < 2; k++) begin wd[k] = rnd512(); ws[k] = '1; end
        do_write(8'h31, 32'(4094 * 64), 1, -1);
        for (int k = 0; k < 2; k++) begin wd[k] = rnd512(); ws[k] = '1; end
        do_write(8'h32, 32'(4095 * 64), 1, -1);
        do_read(8'h33, 32'(4088 * 64), 7, 0);
        do_read(8'h34, 32'(4095 * 64), 1, 0);
        do_read(8'h35, 32'h0, 0, 0);

        // Early wlast on beat 1 of a 3-beat burst
        for (int k = 0; k < 3; k++) begin wd[k] = rnd512(); ws[k] = '1; end
        do_write(8'h40, 32'(20 * 64), 2, 1);
        do_read(8'h41, 32'(20 * 64), 2, 1);

        // Reset during beat 2 of an 8-beat read
        axi.arid = 8'h55; axi.araddr = 32'(8 * 64); axi.arlen = 8'd7; axi.arvalid = 1'b1;
        tick();
        chk("mid_ar_accept", axi.rvalid, 1'b1);
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        tick();
        tick();
        chk("mid_beat2_data", axi.rdata, ref_mem[10]);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", axi.rvalid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_arready", axi.arready, 1'b0);
        axi.rready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_arready", axi.arready, 1'b1);
        do_read(8'h56, 32'(8 * 64), 7, 0);

        // Randomized traffic within the initialised low region
        for (int i = 0; i < 30; i++) begin
            int w, len;
            logic [31:0] a;
            w = $urandom_range(0, 55);
            len = $urandom_range(0, 7);
            a = 32'(w * 64 + $urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= len; k++) begin
                    wd[k] = rnd512();
                    ws[k] = {$urandom, $urandom};
                end
                do_write(8'($urandom), a, len, -1);
            end else begin
                do_read(8'($urandom), a, len, $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
